// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and arithmetic types for the 3x3 convolution engine.
package conv_pkg;

    localparam int IMG_W   = 8;
    localparam int K       = 3;
    localparam int PIX_W   = 8;
    localparam int WGT_W   = 8;
    localparam int ACC_W   = 21;
    localparam int OUT_N   = IMG_W - K + 1;
    localparam int PROD_W  = PIX_W + 1 + WGT_W;
    localparam int COORD_W = 3;
    localparam int ADDR_W  = 2 * COORD_W;
    localparam int WIN_W   = K * K * PIX_W;

    localparam logic [COORD_W-1:0] LAST_C    = COORD_W'(OUT_N - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = {LAST_C, LAST_C};

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [WGT_W-1:0]  wgt_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Pixel is unsigned, so a zero MSB keeps it positive before the signed multiply.
    function automatic prod_t mul_px(input pix_t p, input wgt_t w);
        return $signed({1'b0, p}) * w;
    endfunction

endpackage

// File: rtl/conv3x3_engine_mac9.sv
// Nine pixel*weight multipliers followed by a 9-input adder tree, two register stages.
module mac9
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WIN_W-1:0]   win_in,
    input  logic [WIN_W-1:0]   kernel,
    input  logic               in_valid,
    output logic signed [ACC_W-1:0] sum,
    output logic               out_valid
);

    prod_t prod_d [K*K];
    prod_t prod_q [K*K];
    acc_t  sum_d, sum_q;
    logic  v1_q, v2_q;

    always_comb begin
        for (int k = 0; k < K*K; k++) begin
            prod_d[k] = mul_px(win_in[PIX_W*k +: PIX_W], wgt_t'(kernel[WGT_W*k +: WGT_W]));
        end
    end

    // Each product is sign-extended to the full result width before summing.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < K*K; k++) begin
            sum_d = sum_d + acc_t'(prod_q[k]);
        end
    end

    // NOTE: the product bank is a pipeline register, not a RAM, so it resets like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K*K; k++) prod_q[k] <= '0;
            sum_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            for (int k = 0; k < K*K; k++) prod_q[k] <= prod_d[k];
            sum_q <= sum_d;
            v1_q  <= in_valid;
            v2_q  <= v1_q;
        end
    end

    assign sum       = sum_q;
    assign out_valid = v2_q;

endmodule

// File: rtl/conv3x3_engine.sv
// Scans the 36 valid 3x3 windows of an 8x8 image BRAM and streams signed convolution results.
module conv3x3_engine
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIN_W-1:0]        kernel,
    input  logic [WIN_W-1:0]        win_in,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       addr_out,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    output logic signed [ACC_W-1:0] res_data,
    output logic [ADDR_W-1:0]       res_addr
);

    state_e               state_q;
    logic [COORD_W-1:0]   x_q, y_q, x_d, y_d;
    logic [WIN_W-1:0]     kernel_q;
    logic                 rd_en_q, busy_q;
    logic [ADDR_W-1:0]    addr_q;

    logic [2:0]           v_q, v_d;
    logic [ADDR_W-1:0]    a_q [3];
    logic [ADDR_W-1:0]    a_d [3];
    logic                 done_q, done_d;

    acc_t                 mac_sum;
    logic                 mac_valid;

    // Next window corner, y inner.
    always_comb begin
        if (y_q == LAST_C) begin
            x_d = x_q + 3'd1;
            y_d = '0;
        end else begin
            x_d = x_q;
            y_d = y_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            kernel_q <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SCAN;
                        kernel_q <= kernel;
                        x_q      <= '0;
                        y_q      <= '0;
                        rd_en_q  <= 1'b1;
                        addr_q   <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (x_q == LAST_C && y_q == LAST_C) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        addr_q <= {x_d, y_d};
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Address/valid pipeline tracks the window through the BRAM and the two MAC stages.
    always_comb begin
        v_d    = {v_q[1:0], rd_en_q};
        a_d[0] = addr_q;
        a_d[1] = a_q[0];
        a_d[2] = a_q[1];
        done_d = v_q[1] && (a_q[1] == LAST_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            for (int i = 0; i < 3; i++) a_q[i] <= '0;
            done_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            for (int i = 0; i < 3; i++) a_q[i] <= a_d[i];
            done_q <= done_d;
        end
    end

    mac9 u_mac9 (
        .clk       (clk),
        .rst       (rst),
        .win_in    (win_in),
        .kernel    (kernel_q),
        .in_valid  (v_q[0]),
        .sum       (mac_sum),
        .out_valid (mac_valid)
    );

    assign rd_en     = rd_en_q;
    assign addr_out  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = v_q[2] & mac_valid;
    assign res_data  = mac_sum;
    assign res_addr  = a_q[2];

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine with a 1-cycle-latency window BRAM model.
module tb_conv3x3_engine;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [71:0]       kernel;
    logic [71:0]       win_in = '0;
    logic              rd_en;
    logic [5:0]        addr_out;
    logic              busy;
    logic              done;
    logic              res_valid;
    logic signed [20:0] res_data;
    logic [5:0]        res_addr;

    conv3x3_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .kernel    (kernel),
        .win_in    (win_in),
        .rd_en     (rd_en),
        .addr_out  (addr_out),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_addr  (res_addr)
    );

    always #5 clk = ~clk;

    localparam logic [71:0] K_ID   = 72'd1 << 32;
    localparam logic [71:0] K_ONES = {9{8'h01}};
    localparam logic [71:0] K_NEG  = {9{8'h80}};

    pix_t img [8][8];

    always @(posedge clk) begin
        if (rd_en) begin
            for (int k = 0; k < 9; k++) begin
                win_in[8*k +: 8] <= img[int'(addr_out[5:3]) + k/3][int'(addr_out[2:0]) + k%3];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   res_v [$];
    int   res_a [$];
    int   res_c [$];
    int   done_c [$];
    int   done_a [$];
    int   rd_rise [$];
    logic rd_prev = 1'b0;

    always @(negedge clk) begin
        if (res_valid) begin
            res_v.push_back(int'(res_data));
            res_a.push_back(int'(res_addr));
            res_c.push_back(cyc);
        end
        if (done) begin
            done_c.push_back(cyc);
            done_a.push_back(int'(res_addr));
        end
        if (rd_en && !rd_prev) rd_rise.push_back(cyc);
        rd_prev = rd_en;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_conv(input int x, input int y, input logic [71:0] k);
        int   s;
        wgt_t w;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            w = k[8*i +: 8];
            s += int'(img[x + i/3][y + i%3]) * int'(w);
        end
        return s;
    endfunction

    task automatic fill_ramp();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                img[x][y] = pix_t'(8*x + y);
    endtask

    task automatic clear_logs();
        res_v.delete(); res_a.delete(); res_c.delete();
        done_c.delete(); done_a.delete(); rd_rise.delete();
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, " rd_en"},     rd_en,     0);
        check({tag, " addr_out"},  addr_out,  0);
        check({tag, " busy"},      busy,      0);
        check({tag, " done"},      done,      0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_data"},  res_data,  0);
        check({tag, " res_addr"},  res_addr,  0);
    endtask

    task automatic wait_idle(input string tag, output int t_idle);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle within bound"}, busy, 0);
        t_idle = cyc;
    endtask

    task automatic frame(input string tag, input logic [71:0] k, output int t0, output int t_idle);
        clear_logs();
        @(negedge clk);
        kernel = k;
        start  = 1'b1;
        t0     = cyc;
        @(negedge clk);
        start  = 1'b0;
        wait_idle(tag, t_idle);
    endtask

    task automatic frame_common(input string tag, input int t0, input int t_idle, input logic [71:0] k);
        check({tag, " result count"}, res_v.size(), 36);
        check({tag, " done count"},   done_c.size(), 1);
        check({tag, " rd_en rise"},   (rd_rise.size() > 0) ? rd_rise[0] : -1, t0 + 1);
        check({tag, " first res cyc"}, (res_c.size() > 0) ? res_c[0] : -1, t0 + 4);
        check({tag, " last res cyc"},  (res_c.size() > 0) ? res_c[res_c.size()-1] : -1, t0 + 39);
        check({tag, " done cyc"},      (done_c.size() > 0) ? done_c[0] : -1, t0 + 39);
        check({tag, " done addr"},     (done_a.size() > 0) ? done_a[0] : -1, 45);
        check({tag, " busy fall cyc"}, t_idle, t0 + 40);
        for (int i = 0; i < res_v.size() && i < 36; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), res_a[i], ((i/6) << 3) | (i%6));
            check($sformatf("%s data[%0d]", tag, i), res_v[i], ref_conv(i/6, i%6, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        int t0, t_idle, n, first_cnt;

        rst    = 1'b1;
        start  = 1'b0;
        kernel = '0;
        fill_ramp();
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Identity kernel: each result is the window centre pixel.
        frame("id", K_ID, t0, t_idle);
        frame_common("id", t0, t_idle, K_ID);
        check("id (0,0)", (res_v.size() > 0)  ? res_v[0]  : -1, 9);
        check("id (0,5)", (res_v.size() > 5)  ? res_v[5]  : -1, 14);
        check("id (5,5)", (res_v.size() > 35) ? res_v[35] : -1, 54);

        frame("ones", K_ONES, t0, t_idle);
        frame_common("ones", t0, t_idle, K_ONES);
        check("ones (0,0)", (res_v.size() > 0)  ? res_v[0]  : -1, 81);
        check("ones (5,5)", (res_v.size() > 35) ? res_v[35] : -1, 486);

        // Most negative product sum exercises sign extension to 21 bits.
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                img[x][y] = 8'hFF;
        frame("neg", K_NEG, t0, t_idle);
        check("neg result count", res_v.size(), 36);
        for (int i = 0; i < res_v.size(); i++)
            check($sformatf("neg data[%0d]", i), res_v[i], -293760);
        fill_ramp();

        // Reset in the middle of a frame.
        clear_logs();
        @(negedge clk);
        kernel = K_ID;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n = 0;
        while (res_v.size() < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst reached 10 results", res_v.size(), 10);
        rst = 1'b1;
        #1;
        outputs_zero("midrst async");
        repeat (2) @(negedge clk);
        outputs_zero("midrst held");
        rst = 1'b0;
        clear_logs();
        repeat (10) @(negedge clk);
        check("midrst no partial results", res_v.size(), 0);
        check("midrst busy after release", busy, 0);
        frame("post_rst", K_ID, t0, t_idle);
        frame_common("post_rst", t0, t_idle, K_ID);
        check("post_rst first", (res_v.size() > 0) ? res_v[0] : -1, 9);

        // Starts at T+5 and T+39 are ignored; the one at T+40 is accepted.
        clear_logs();
        @(negedge clk);
        kernel = K_ONES;
        start  = 1'b1;
        t0     = cyc;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 39 || c == 40);
        end
        wait_idle("restart", t_idle);
        first_cnt = 0;
        foreach (res_c[i]) if (res_c[i] <= t0 + 40) first_cnt++;
        check("restart first frame results", first_cnt, 36);
        check("restart total results", res_v.size(), 72);
        check("restart rd_en rises", rd_rise.size(), 2);
        check("restart first rise", (rd_rise.size() > 0) ? rd_rise[0] : -1, t0 + 1);
        check("restart second rise", (rd_rise.size() > 1) ? rd_rise[1] : -1, t0 + 41);
        check("restart first done", (done_c.size() > 0) ? done_c[0] : -1, t0 + 39);
        check("restart second frame first res", (res_c.size() > 36) ? res_c[36] : -1, t0 + 44);
        check("restart second frame (0,0)", (res_v.size() > 36) ? res_v[36] : -1, 81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
